// File: rtl/memory_stage_if.sv
// memory_stage_if: groups the Execute-side inputs, Writeback-side outputs and data-memory port of memory_stage.
// Latency: none; this is a plain signal bundle.
// Backpressure: stall flows back to Execute, while dmem_ready paces the memory access.
interface memory_stage_if;
    // Execute -> memory stage
    logic        valid_mem;
    logic [0:31] insn;
    logic [0:31] alu_result;
    logic [0:31] rt;
    // Memory stage -> Execute / Writeback
    logic        stall;
    logic [0:31] data_out;
    logic        valid_wb;
    logic        addr_err;
    // Data memory port
    logic        dmem_req;
    logic        dmem_we;
    logic [0:31] dmem_addr;
    logic [0:31] dmem_wdata;
    logic [0:3]  dmem_be;
    logic        dmem_ready;
    logic [0:31] dmem_rdata;

    // The stage itself
    modport slave (
        input  valid_mem, insn, alu_result, rt, dmem_ready, dmem_rdata,
        output stall, data_out, valid_wb, addr_err,
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
    );

    // The surroundings driving the stage: the Execute stage, Writeback and memory
    modport master (
        output valid_mem, insn, alu_result, rt, dmem_ready, dmem_rdata,
        input  stall, data_out, valid_wb, addr_err,
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: data-memory pipeline stage; it handles loads and stores and passes other results straight through.
// Latency: a pass-through result appears 1 cycle after acceptance. A load takes 2 cycles plus the dmem wait cycles.
// Backpressure: stall stays high for the whole ACCESS state, and the dmem request is held stable until dmem_ready.
// Build option: defining MEMORY_STAGE_HALFWORD_LOAD_EN adds LH/LHU halfword loads.
module memory_stage (
    input  logic          clock,
    input  logic          reset,
    memory_stage_if.slave bus
);

    localparam logic [0:5] OP_LW  = 6'b100011;
    localparam logic [0:5] OP_LB  = 6'b100000;
    localparam logic [0:5] OP_LBU = 6'b100100;
    localparam logic [0:5] OP_SW  = 6'b101011;
    localparam logic [0:5] OP_SB  = 6'b101000;
    localparam logic [0:5] OP_SH  = 6'b101001;
    localparam logic [0:5] OP_LH  = 6'b100001;
    localparam logic [0:5] OP_LHU = 6'b100101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        stall_q, stall_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [0:3]  dmem_be_q, dmem_be_d;
    logic [0:31] dmem_addr_q, dmem_addr_d;
    logic [0:31] dmem_wdata_q, dmem_wdata_d;
    logic [0:31] data_out_q, data_out_d;
    logic        valid_wb_q, valid_wb_d;
    logic        addr_err_q, addr_err_d;
    logic [0:5]  op_q, op_d;
    logic [0:1]  lane_q, lane_d;

    // Decode of the incoming instruction
    logic [0:5]  opcode;
    logic [0:1]  lane;
    logic        is_lw, is_lb, is_lbu, is_sw, is_sb, is_sh, is_lh, is_lhu;
    logic        is_load, is_store, is_mem, misaligned;
    logic [0:3]  store_be;
    logic [0:31] store_wdata;
    logic [0:7]  load_byte;
    logic [0:31] load_data;

    // Only the opcode field of insn matters to this stage
    logic unused_insn;
    assign unused_insn = ^bus.insn[6:31];

    // Classify the incoming instruction and check its alignment
    always_comb begin
        opcode = bus.insn[0:5];
        lane   = bus.alu_result[30:31];
        is_lw  = (opcode == OP_LW);
        is_lb  = (opcode == OP_LB);
        is_lbu = (opcode == OP_LBU);
        is_sw  = (opcode == OP_SW);
        is_sb  = (opcode == OP_SB);
        is_sh  = (opcode == OP_SH);
`ifdef MEMORY_STAGE_HALFWORD_LOAD_EN
        is_lh  = (opcode == OP_LH);
        is_lhu = (opcode == OP_LHU);
`else
        // Without halfword loads these opcodes take the ALU pass-through path
        is_lh  = 1'b0;
        is_lhu = 1'b0;
`endif
        is_load    = is_lw | is_lb | is_lbu | is_lh | is_lhu;
        is_store   = is_sw | is_sb | is_sh;
        is_mem     = is_load | is_store;
        misaligned = ((is_lw | is_sw) & (lane != 2'b00))
                   | ((is_sh | is_lh | is_lhu) & lane[1]);
    end

    // Store byte enables and lane-replicated write data. Lanes are big-endian: lane 0 is bits [0:7].
    always_comb begin
        store_be    = 4'b0000;
        store_wdata = 32'h0000_0000;
        if (is_sw) begin
            store_be    = 4'b1111;
            store_wdata = bus.rt;
        end else if (is_sb) begin
            store_wdata = {4{bus.rt[24:31]}};
            case (lane)
                2'b00:   store_be = 4'b1000;
                2'b01:   store_be = 4'b0100;
                2'b10:   store_be = 4'b0010;
                default: store_be = 4'b0001;
            endcase
        end else if (is_sh) begin
            store_wdata = {2{bus.rt[16:31]}};
            store_be    = lane[0] ? 4'b0011 : 4'b1100;
        end
    end

    // Select and extend the returned lane for the latched load opcode
    always_comb begin
        case (lane_q)
            2'b00:   load_byte = bus.dmem_rdata[0:7];
            2'b01:   load_byte = bus.dmem_rdata[8:15];
            2'b10:   load_byte = bus.dmem_rdata[16:23];
            default: load_byte = bus.dmem_rdata[24:31];
        endcase
        load_data = bus.dmem_rdata;
        if (op_q == OP_LB) begin
            load_data = {{24{load_byte[0]}}, load_byte};
        end else if (op_q == OP_LBU) begin
            load_data = {24'h000000, load_byte};
        end
`ifdef MEMORY_STAGE_HALFWORD_LOAD_EN
        else if (op_q == OP_LH) begin
            load_data = lane_q[0] ? {{16{bus.dmem_rdata[16]}}, bus.dmem_rdata[16:31]}
                                  : {{16{bus.dmem_rdata[0]}},  bus.dmem_rdata[0:15]};
        end else if (op_q == OP_LHU) begin
            load_data = lane_q[0] ? {16'h0000, bus.dmem_rdata[16:31]}
                                  : {16'h0000, bus.dmem_rdata[0:15]};
        end
`endif
    end

    // Next-state logic: accept from Execute in IDLE, then wait on dmem_ready in ACCESS
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        data_out_d   = data_out_q;
        op_d         = op_q;
        lane_d       = lane_q;
        valid_wb_d   = 1'b0;
        addr_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // dmem_ready is deliberately not looked at here
                if (bus.valid_mem) begin
                    if (is_mem && misaligned) begin
                        addr_err_d = 1'b1;
                    end else if (is_mem) begin
                        state_d      = ACCESS;
                        op_d         = opcode;
                        lane_d       = lane;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {bus.alu_result[0:29], 2'b00};
                        // Loads read the whole word and pick the lane on return
                        dmem_be_d    = is_store ? store_be : 4'b1111;
                        dmem_wdata_d = store_wdata;
                    end else begin
                        data_out_d = bus.alu_result;
                        valid_wb_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (bus.dmem_ready) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    dmem_be_d  = 4'b0000;
                    // Stores complete silently; only loads produce a result
                    if (op_q[2] == 1'b0) begin
                        data_out_d = load_data;
                        valid_wb_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        stall_d = (state_d == ACCESS);
    end

    // State and registered outputs. Reset wins over any same-cycle request or dmem_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            stall_q      <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'b0000;
            dmem_addr_q  <= 32'h0000_0000;
            dmem_wdata_q <= 32'h0000_0000;
            data_out_q   <= 32'h0000_0000;
            valid_wb_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            op_q         <= 6'b000000;
            lane_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            data_out_q   <= data_out_d;
            valid_wb_q   <= valid_wb_d;
            addr_err_q   <= addr_err_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
        end
    end

    assign bus.stall      = stall_q;
    assign bus.data_out   = data_out_q;
    assign bus.valid_wb   = valid_wb_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;

endmodule
